rps_scoreboard: RTL

Parametrised successor to the game's result/score stage. It judges each round exactly once and keeps multi-digit BCD win, loss and draw tallies. It adds best-of-N match tracking and drives the result LEDs and 7-segment digits. It sits between the game-state FSM (which supplies `state` and moves) and the board LED/HEX outputs.

---
 rtl/rps_pkg.sv | 66 ++++++
 rtl/rps_bcd_counter.sv | 42 ++++
 rtl/rps_scoreboard.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared codes, segment glyphs and judging helpers for the RPS scoreboard
package rps_pkg;

    typedef enum logic [1:0] {ROCK = 2'd0, PAPER = 2'd1, SCISSORS = 2'd2, INVALID = 2'd3} move_t;
    typedef enum logic [1:0] {LOSE = 2'd0, DRAW = 2'd1, WIN = 2'd2, BAD = 2'd3} result_t;
    typedef enum logic [1:0] {S_WAIT = 2'd0, S_MOVE = 2'd1, S_RESULT = 2'd2, S_BLANK = 2'd3} state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_P     = 8'h8C;
    localparam logic [7:0] SEG_S     = 8'h92;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_of_bcd(input logic [3:0] nibble);
        case (nibble)
            4'd0:    seg_of_bcd = SEG_0;
            4'd1:    seg_of_bcd = SEG_1;
            4'd2:    seg_of_bcd = SEG_2;
            4'd3:    seg_of_bcd = SEG_3;
            4'd4:    seg_of_bcd = SEG_4;
            4'd5:    seg_of_bcd = SEG_5;
            4'd6:    seg_of_bcd = SEG_6;
            4'd7:    seg_of_bcd = SEG_7;
            4'd8:    seg_of_bcd = SEG_8;
            4'd9:    seg_of_bcd = SEG_9;
            default: seg_of_bcd = SEG_E;
        endcase
    endfunction

    function automatic logic [7:0] seg_of_move(input logic [1:0] m);
        case (m)
            ROCK:     seg_of_move = SEG_R;
            PAPER:    seg_of_move = SEG_P;
            SCISSORS: seg_of_move = SEG_S;
            default:  seg_of_move = SEG_BLANK;
        endcase
    endfunction

    function automatic result_t judge(input logic [1:0] u, input logic [1:0] c);
        if (u == INVALID || c == INVALID)
            judge = BAD;
        else if (u == c)
            judge = DRAW;
        else if ({u, c} == {PAPER, ROCK} || {u, c} == {ROCK, SCISSORS} || {u, c} == {SCISSORS, PAPER})
            judge = WIN;
        else
            judge = LOSE;
    endfunction

endpackage

// File: rtl/rps_bcd_counter.sv
// rtl/rps_bcd_counter.sv - multi-digit BCD up-counter with synchronous clear
module rps_bcd_counter
    import rps_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   count
);

    logic [4*DIGITS-1:0] count_nxt;
    logic                carry;

    // Ripple a carry from the least significant digit; all-nines wraps to zero
    always_comb begin
        count_nxt = count;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] >= BCD_MAX) begin
                    count_nxt[4*i +: 4] = 4'd0;
                end else begin
                    count_nxt[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count_nxt;
    end

endmodule

// File: rtl/rps_scoreboard.sv
// rtl/rps_scoreboard.sv - judges each round once, keeps BCD tallies, tracks best-of-N and drives LEDs/HEX
module rps_scoreboard
    import rps_pkg::*;
#(
    parameter int DIGITS         = 2,
    parameter int MATCH_WINS     = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            state,
    input  logic [1:0]            user_move,
    input  logic [1:0]            computer_move,
    input  logic                  clear_scores,
    output logic [1:0]            result,
    output logic                  result_valid,
    output logic                  match_over,
    output logic                  match_winner,
    output logic [4*DIGITS-1:0]   win_count,
    output logic [4*DIGITS-1:0]   loss_count,
    output logic [4*DIGITS-1:0]   draw_count,
    output logic [8*DIGITS-1:0]   seg_win,
    output logic [8*DIGITS-1:0]   seg_loss,
    output logic [9:0]            LEDn,
    output logic [7:0]            Digit2,
    output logic [7:0]            Digit1,
    output logic [7:0]            Digit0
);

    localparam bit              MATCH_ON = (MATCH_WINS > 0);
    localparam int              MW_W     = MATCH_ON ? $clog2(MATCH_WINS + 1) : 1;
    localparam logic [MW_W-1:0] MW_LAST  = MW_W'(MATCH_ON ? MATCH_WINS - 1 : 0);
    localparam logic [7:0]      SEG_POL  = SEG_ACTIVE_LOW ? 8'h00 : 8'hFF;

    state_t          st;
    result_t         judged, disp_res, result_q;
    logic            scored, score_now, show;
    logic            win_inc, loss_inc, draw_inc;
    logic            hit_user, hit_comp, mo_nxt;
    logic [MW_W-1:0] user_wins, comp_wins;
    logic [9:0]      led_q, led_d;
    logic [7:0]      d2_q, d1_q, d0_q, d2_d, d1_d, d0_d;

    assign st = state_t'(state);

    always_comb begin
        judged    = judge(user_move, computer_move);
        score_now = (st == S_RESULT) && !scored && !match_over && !clear_scores;
        win_inc   = score_now && (judged == WIN);
        loss_inc  = score_now && (judged == LOSE);
        draw_inc  = score_now && (judged == DRAW);
        hit_user  = MATCH_ON && win_inc && (user_wins == MW_LAST);
        hit_comp  = MATCH_ON && loss_inc && (comp_wins == MW_LAST);
        mo_nxt    = !clear_scores && (match_over || hit_user || hit_comp);
        show      = score_now || scored;
        disp_res  = score_now ? judged : result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scored       <= 1'b0;
            result_q     <= LOSE;
            result_valid <= 1'b0;
            user_wins    <= '0;
            comp_wins    <= '0;
            match_over   <= 1'b0;
            match_winner <= 1'b0;
        end else begin
            result_valid <= score_now;
            if (score_now)
                result_q <= judged;
            // A clear in the result state consumes the round so it is never scored late
            if (st == S_WAIT)
                scored <= 1'b0;
            else if (st == S_RESULT && (score_now || clear_scores))
                scored <= 1'b1;
            if (clear_scores) begin
                user_wins    <= '0;
                comp_wins    <= '0;
                match_over   <= 1'b0;
                match_winner <= 1'b0;
            end else begin
                if (MATCH_ON && win_inc)
                    user_wins <= user_wins + MW_W'(1);
                if (MATCH_ON && loss_inc)
                    comp_wins <= comp_wins + MW_W'(1);
                if (hit_user || hit_comp) begin
                    match_over   <= 1'b1;
                    match_winner <= hit_user;
                end
            end
        end
    end

    always_comb begin
        led_d = led_q;
        d2_d  = d2_q;
        d1_d  = d1_q;
        d0_d  = d0_q;
        case (st)
            S_WAIT: begin
                led_d = 10'b0000000001;
                d2_d  = SEG_BLANK;
                d1_d  = SEG_BLANK;
                d0_d  = SEG_0;
            end
            S_MOVE: begin
                led_d = 10'b0000001110;
                d2_d  = SEG_BLANK;
                d1_d  = SEG_BLANK;
                d0_d  = SEG_0;
            end
            S_RESULT: begin
                // Rounds ignored after a match ends leave the digits untouched
                if (show) begin
                    d2_d = seg_of_move(computer_move);
                    case (disp_res)
                        WIN:     begin led_d = 10'b1010101010; d1_d = SEG_A; d0_d = SEG_BLANK; end
                        LOSE:    begin led_d = 10'b1111100000; d1_d = SEG_L; d0_d = SEG_BLANK; end
                        DRAW:    begin led_d = 10'b1111111111; d1_d = SEG_D; d0_d = SEG_D;     end
                        default: begin led_d = 10'b1000000001; d1_d = SEG_E; d0_d = SEG_E;     end
                    endcase
                end
                if (mo_nxt)
                    led_d = 10'b1100000011;
            end
            default: begin
                led_d = 10'b0000000000;
                d2_d  = SEG_BLANK;
                d1_d  = SEG_BLANK;
                d0_d  = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
            d2_q  <= SEG_BLANK;
            d1_q  <= SEG_BLANK;
            d0_q  <= SEG_BLANK;
        end else begin
            led_q <= led_d;
            d2_q  <= d2_d;
            d1_q  <= d1_d;
            d0_q  <= d0_d;
        end
    end

    rps_bcd_counter #(.DIGITS(DIGITS)) u_win  (.clk(clk), .rst_n(rst_n), .clr(clear_scores), .inc(win_inc),  .count(win_count));
    rps_bcd_counter #(.DIGITS(DIGITS)) u_loss (.clk(clk), .rst_n(rst_n), .clr(clear_scores), .inc(loss_inc), .count(loss_count));
    rps_bcd_counter #(.DIGITS(DIGITS)) u_draw (.clk(clk), .rst_n(rst_n), .clr(clear_scores), .inc(draw_inc), .count(draw_count));

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        assign seg_win[8*i +: 8]  = seg_of_bcd(win_count[4*i +: 4]) ^ SEG_POL;
        assign seg_loss[8*i +: 8] = seg_of_bcd(loss_count[4*i +: 4]) ^ SEG_POL;
    end

    assign result = result_q;
    assign LEDn   = led_q;
    assign Digit2 = d2_q ^ SEG_POL;
    assign Digit1 = d1_q ^ SEG_POL;
    assign Digit0 = d0_q ^ SEG_POL;

endmodule
